// File: rtl/uio_tx_pkg.sv
// Shared types and constants for the uio byte transmitter.
package uio_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        WAIT_ACK_H,
        WAIT_ACK_L,
        TURN
    } tx_state_t;

    localparam logic [7:0] OE_ON  = 8'hFF;
    localparam logic [7:0] OE_OFF = 8'h00;

endpackage

// File: rtl/uio_tx_fifo.sv
// Small circular byte FIFO; pointers carry one extra wrap bit to tell full from empty.
module uio_tx_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] wr_data,
    input  logic       wr_en,
    input  logic       rd_en,
    output logic [7:0] rd_data,
    output logic       full,
    output logic       empty
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]  mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        push;
    logic        pop;

    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign push    = wr_en && !full;
    assign pop     = rd_en && !empty;
    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            // NOTE: sequential state is written with <= so every flop samples pre-edge values.
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // NOTE: storage is deliberately not reset; the pointers alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/uio_byte_tx.sv
// Transmit side of the uio byte port: queues bytes, then drives each one out with a
// 4-phase req/ack handshake, releasing the bus between bytes.
module uio_byte_tx
    import uio_tx_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int SETUP_CYC = 1,
    parameter int TIMEOUT   = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] wr_data,
    input  logic       wr_en,
    output logic       full,
    output logic       empty,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe,
    output logic       req_out,
    input  logic       ack_in,
    output logic       busy,
    output logic       err,
    input  logic       err_clr
);

    localparam logic [3:0] SETUP_LOAD = 4'(SETUP_CYC - 1);
    localparam logic [7:0] TMO_LOAD   = 8'(TIMEOUT);

    tx_state_t  state, state_nxt;
    logic [3:0] setup_cnt, setup_nxt;
    logic [7:0] tmo_cnt, tmo_nxt;
    logic [7:0] data_q, data_nxt;
    logic       oe_q, oe_nxt;
    logic       req_q, req_nxt;
    logic       err_q, err_nxt;
    logic       abort;
    logic       rd_en;
    logic [7:0] fifo_data;
    logic       ack_s1, ack_s;

    uio_tx_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_data (wr_data),
        .wr_en   (wr_en),
        .rd_en   (rd_en),
        .rd_data (fifo_data),
        .full    (full),
        .empty   (empty)
    );

    // ack_in comes from off-chip with no timing relation to clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_s1 <= 1'b0;
            ack_s  <= 1'b0;
        end else begin
            ack_s1 <= ack_in;
            ack_s  <= ack_s1;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_nxt = state;
        setup_nxt = setup_cnt;
        tmo_nxt   = tmo_cnt;
        data_nxt  = data_q;
        oe_nxt    = oe_q;
        req_nxt   = req_q;
        rd_en     = 1'b0;
        abort     = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    rd_en     = 1'b1;
                    data_nxt  = fifo_data;
                    oe_nxt    = 1'b1;
                    setup_nxt = SETUP_LOAD;
                    state_nxt = SETUP;
                end
            end
            SETUP: begin
                if (setup_cnt == 4'd0) begin
                    req_nxt   = 1'b1;
                    tmo_nxt   = TMO_LOAD;
                    state_nxt = WAIT_ACK_H;
                end else begin
                    setup_nxt = setup_cnt - 4'd1;
                end
            end
            WAIT_ACK_H: begin
                if (ack_s) begin
                    req_nxt   = 1'b0;
                    tmo_nxt   = TMO_LOAD;
                    state_nxt = WAIT_ACK_L;
                end else if (tmo_cnt == 8'd0) begin
                    abort = 1'b1;
                end else begin
                    tmo_nxt = tmo_cnt - 8'd1;
                end
            end
            WAIT_ACK_L: begin
                if (!ack_s) begin
                    oe_nxt    = 1'b0;
                    data_nxt  = 8'h00;
                    state_nxt = TURN;
                end else if (tmo_cnt == 8'd0) begin
                    abort = 1'b1;
                end else begin
                    tmo_nxt = tmo_cnt - 8'd1;
                end
            end
            TURN:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        if (abort) begin
            req_nxt   = 1'b0;
            oe_nxt    = 1'b0;
            data_nxt  = 8'h00;
            state_nxt = TURN;
        end
        // A timeout in the same cycle as err_clr must still be reported.
        err_nxt = abort ? 1'b1 : (err_clr ? 1'b0 : err_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            setup_cnt <= '0;
            tmo_cnt   <= '0;
            data_q    <= '0;
            oe_q      <= 1'b0;
            req_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state     <= state_nxt;
            setup_cnt <= setup_nxt;
            tmo_cnt   <= tmo_nxt;
            data_q    <= data_nxt;
            oe_q      <= oe_nxt;
            req_q     <= req_nxt;
            err_q     <= err_nxt;
        end
    end

    assign uio_out = data_q;
    assign uio_oe  = oe_q ? OE_ON : OE_OFF;
    assign req_out = req_q;
    assign err     = err_q;
    assign busy    = (state != IDLE);

endmodule

// File: tb/tb_uio_byte_tx.sv
// Self-checking bench for uio_byte_tx: a queue-level FIFO/bus model checked every cycle,
// plus directed handshake, timeout, overflow and reset scenarios with hand-derived timing.
module tb_uio_byte_tx;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] wr_data;
    logic       wr_en;
    logic       full;
    logic       empty;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;
    logic       req_out;
    logic       ack_in;
    logic       busy;
    logic       err;
    logic       err_clr;

    int n_pass  = 0;
    int n_total = 0;

    uio_byte_tx #(.DEPTH(DEPTH), .SETUP_CYC(1), .TIMEOUT(10)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_data (wr_data),
        .wr_en   (wr_en),
        .full    (full),
        .empty   (empty),
        .uio_out (uio_out),
        .uio_oe  (uio_oe),
        .req_out (req_out),
        .ack_in  (ack_in),
        .busy    (busy),
        .err     (err),
        .err_clr (err_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
    endtask

    // Bus model: bytes accepted into a bounded queue leave it, in order, each time the bus is
    // newly claimed; while claimed the bus must show that byte, and when released it shows 0.
    logic [7:0] model_q[$];
    logic [7:0] cur_byte;
    logic       prev_oe;
    logic       prev_wr;
    logic [7:0] prev_wd;
    logic       was_full;

    initial begin
        cur_byte = 8'h00;
        prev_oe  = 1'b0;
        prev_wr  = 1'b0;
        prev_wd  = 8'h00;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                model_q.delete();
                cur_byte = 8'h00;
                prev_oe  = 1'b0;
                prev_wr  = 1'b0;
            end else begin
                was_full = (model_q.size() == DEPTH);
                if (!prev_oe && uio_oe == 8'hFF) begin
                    check("m_pop_nonempty", 32'(model_q.size() != 0), 32'd1);
                    if (model_q.size() != 0) cur_byte = model_q.pop_front();
                    check("m_byte_order", 32'(uio_out), 32'(cur_byte));
                end
                if (prev_wr && !was_full) model_q.push_back(prev_wd);
                check("m_full", 32'(full), 32'(model_q.size() == DEPTH));
                check("m_empty", 32'(empty), 32'(model_q.size() == 0));
                check("m_oe_legal", 32'(uio_oe == 8'h00 || uio_oe == 8'hFF), 32'd1);
                if (uio_oe == 8'hFF) check("m_data_stable", 32'(uio_out), 32'(cur_byte));
                else                 check("m_data_released", 32'(uio_out), 32'd0);
                if (req_out) check("m_req_needs_oe", 32'(uio_oe), 32'hFF);
                if (!busy)   check("m_idle_quiet", 32'({req_out, uio_oe}), 32'd0);
                prev_oe = (uio_oe == 8'hFF);
                prev_wr = wr_en;
                prev_wd = wr_data;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic push(input logic [7:0] b);
        wr_en   = 1'b1;
        wr_data = b;
        tick();
        wr_en   = 1'b0;
    endtask

    // Wait (bounded) until req_out (on_req=1) or the bus enable (on_req=0) equals val.
    task automatic wait_for(input string name, input bit on_req, input logic val, input int lim);
        bit ok = 1'b0;
        int i  = 0;
        while (!ok && i < lim) begin
            if ((on_req ? req_out : uio_oe[0]) == val) ok = 1'b1;
            else begin
                tick();
                i++;
            end
        end
        check(name, 32'(ok), 32'd1);
    endtask

    // Act as a prompt peer for one byte and return what the bus carried.
    task automatic xfer(output logic [7:0] got);
        wait_for("xfer_req_rise", 1'b1, 1'b1, 40);
        got    = uio_out;
        ack_in = 1'b1;
        wait_for("xfer_req_fall", 1'b1, 1'b0, 10);
        ack_in = 1'b0;
        wait_for("xfer_oe_release", 1'b0, 1'b0, 10);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] got;
        rst_n   = 1'b0;
        wr_en   = 1'b0;
        wr_data = 8'h00;
        ack_in  = 1'b0;
        err_clr = 1'b0;

        // Reset values
        ticks(3);
        rst_n = 1'b1;
        tick();
        check("rst_uio_out", 32'(uio_out), 32'h00);
        check("rst_uio_oe", 32'(uio_oe), 32'h00);
        check("rst_req", 32'(req_out), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_full", 32'(full), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);

        // Single byte A5, peer raises ack 3 edges after req
        push(8'hA5);
        check("a5_not_empty", 32'(empty), 32'd0);
        check("a5_oe_before", 32'(uio_oe), 32'h00);
        tick();
        check("a5_oe_on", 32'(uio_oe), 32'hFF);
        check("a5_data", 32'(uio_out), 32'hA5);
        check("a5_busy", 32'(busy), 32'd1);
        check("a5_req_setup", 32'(req_out), 32'd0);
        tick();
        check("a5_req_rise", 32'(req_out), 32'd1);
        ticks(2);
        ack_in = 1'b1;
        ticks(2);
        check("a5_req_hold", 32'(req_out), 32'd1);
        tick();
        check("a5_req_fall", 32'(req_out), 32'd0);
        check("a5_oe_hold", 32'(uio_oe), 32'hFF);
        ack_in = 1'b0;
        ticks(2);
        check("a5_oe_hold2", 32'(uio_oe), 32'hFF);
        check("a5_data_hold", 32'(uio_out), 32'hA5);
        tick();
        check("a5_oe_off", 32'(uio_oe), 32'h00);
        check("a5_turn_busy", 32'(busy), 32'd1);
        tick();
        check("a5_idle", 32'(busy), 32'd0);

        // Overflow while the peer stalls on F0, then push coinciding with a pop while full
        push(8'hF0);
        wait_for("f0_req", 1'b1, 1'b1, 10);
        for (int i = 1; i <= 4; i++) push(8'(i));
        check("ovf_full", 32'(full), 32'd1);
        push(8'h05);
        check("ovf_full_hold", 32'(full), 32'd1);
        xfer(got);
        check("ovf_f0", 32'(got), 32'hF0);
        tick();
        wr_en   = 1'b1;
        wr_data = 8'hEE;
        tick();
        wr_en   = 1'b0;
        check("pushpop_full_drop", 32'(full), 32'd0);
        check("pushpop_oe", 32'(uio_oe), 32'hFF);
        check("pushpop_head", 32'(uio_out), 32'h01);
        for (int i = 1; i <= 4; i++) begin
            xfer(got);
            check("drain_order", 32'(got), 32'(i));
        end
        ticks(2);
        check("drain_empty", 32'(empty), 32'd1);
        check("drain_idle", 32'(busy), 32'd0);

        // Peer never acks 3C: abort 11 cycles into the handshake, then 7E goes out
        push(8'h3C);
        push(8'h7E);
        ticks(11);
        check("to_req_still", 32'(req_out), 32'd1);
        check("to_err_before", 32'(err), 32'd0);
        tick();
        check("to_err", 32'(err), 32'd1);
        check("to_req_drop", 32'(req_out), 32'd0);
        check("to_oe_drop", 32'(uio_oe), 32'h00);
        check("to_turn_busy", 32'(busy), 32'd1);
        tick();
        check("to_idle", 32'(busy), 32'd0);
        tick();
        check("to_next_oe", 32'(uio_oe), 32'hFF);
        check("to_next_data", 32'(uio_out), 32'h7E);
        xfer(got);
        check("to_next_byte", 32'(got), 32'h7E);
        check("to_err_sticky", 32'(err), 32'd1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("err_cleared", 32'(err), 32'd0);

        // ack held high: abort in the release phase, coinciding with err_clr
        push(8'h5A);
        wait_for("wl_req", 1'b1, 1'b1, 10);
        ack_in = 1'b1;
        wait_for("wl_req_fall", 1'b1, 1'b0, 10);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("wl_req_low", 32'(req_out), 32'd0);
        end
        check("wl_oe_hold", 32'(uio_oe), 32'hFF);
        check("wl_err_before", 32'(err), 32'd0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("wl_err_set_wins", 32'(err), 32'd1);
        check("wl_oe_drop", 32'(uio_oe), 32'h00);
        check("wl_req_turn", 32'(req_out), 32'd0);
        tick();
        check("wl_idle", 32'(busy), 32'd0);
        check("wl_req_idle", 32'(req_out), 32'd0);
        ack_in = 1'b0;
        ticks(3);

        // Asynchronous reset mid-handshake with three bytes still queued
        push(8'h11);
        push(8'h22);
        push(8'h33);
        push(8'h44);
        wait_for("mr_req", 1'b1, 1'b1, 10);
        check("mr_queued", 32'(empty), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("mr_req_async", 32'(req_out), 32'd0);
        check("mr_oe_async", 32'(uio_oe), 32'h00);
        check("mr_data_async", 32'(uio_out), 32'h00);
        check("mr_empty_async", 32'(empty), 32'd1);
        check("mr_busy_async", 32'(busy), 32'd0);
        ticks(2);
        rst_n = 1'b1;
        tick();
        check("mr_empty", 32'(empty), 32'd1);
        check("mr_busy", 32'(busy), 32'd0);
        check("mr_err", 32'(err), 32'd0);
        push(8'h66);
        xfer(got);
        check("mr_first_after", 32'(got), 32'h66);
        ticks(2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
